// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared definitions for the pipeline stall controller: stall vectors, stage
// bit positions and the multi-cycle sequencer state encoding.
package pipe_stall_ctrl_pkg;

    localparam int STALL_W = 6;
    localparam int CNT_W   = 6;

    // Stage bit positions inside stall_en
    localparam int STALL_PC_BIT  = 0;
    localparam int STALL_IF_BIT  = 1;
    localparam int STALL_ID_BIT  = 2;
    localparam int STALL_EX_BIT  = 3;
    localparam int STALL_MEM_BIT = 4;
    localparam int STALL_WB_BIT  = 5;

    // A stall raised by stage k freezes stage k and every earlier stage
    localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
    localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
    localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
    localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;

    typedef enum logic [1:0] {
        MC_IDLE = 2'd0,
        MC_RUN  = 2'd1,
        MC_DONE = 2'd2
    } mc_state_e;

    // A requested occupancy of zero cycles behaves as a single-cycle op
    function automatic logic [CNT_W-1:0] eff_cycles(input logic [CNT_W-1:0] cycles);
        logic [CNT_W-1:0] result;
        if (cycles == 6'd0) begin
            result = 6'd1;
        end else begin
            result = cycles;
        end
        return result;
    endfunction

endpackage

// File: rtl/pipe_stall_enc.sv
// Priority encoder turning per-stage stall requests into one stall vector.
// MEM outranks EX, EX outranks ID; kill forces the empty vector.
module pipe_stall_enc
    import pipe_stall_ctrl_pkg::*;
(
    input  logic               req_id,
    input  logic               req_ex,
    input  logic               req_mem,
    input  logic               kill,
    output logic [STALL_W-1:0] stall_en
);

    // Select the encoding of the deepest requesting stage
    always_comb begin
        stall_en = STALL_NONE;
        if (kill) begin
            stall_en = STALL_NONE;
        end else if (req_mem) begin
            stall_en = STALL_MEM;
        end else if (req_ex) begin
            stall_en = STALL_EX;
        end else if (req_id) begin
            stall_en = STALL_ID;
        end else begin
            stall_en = STALL_NONE;
        end
    end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall controller: merges hazard stall requests with the EX stall
// generated by a multi-cycle op sequencer (IDLE -> RUN -> DONE).
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               stall_req_id,
    input  logic               stall_req_ex,
    input  logic               stall_req_mem,
    input  logic               mc_start,
    input  logic [CNT_W-1:0]   mc_cycles,
    input  logic               mc_ready,
    input  logic               flush,
    output logic [STALL_W-1:0] stall_en,
    output logic               mc_busy,
    output logic               mc_done,
    output logic [CNT_W-1:0]   mc_cnt
);

    mc_state_e        state_r;
    logic [CNT_W-1:0] cnt_r;

    logic [CNT_W-1:0] n_eff_s;
    logic             kill_s;
    logic             op_ex_s;
    logic             done_raw_s;
    logic             start_long_s;
    logic             start_short_s;

    // Decode the sequencer state into its EX stall and completion strobes
    always_comb begin
        n_eff_s       = eff_cycles(mc_cycles);
        kill_s        = reset | flush;
        start_long_s  = mc_start && (n_eff_s >= 6'd2);
        start_short_s = mc_start && (n_eff_s <= 6'd1);
        op_ex_s       = 1'b0;
        done_raw_s    = 1'b0;
        case (state_r)
            MC_IDLE: begin
                op_ex_s    = start_long_s;
                done_raw_s = start_short_s;
            end
            MC_RUN: begin
                op_ex_s    = 1'b1;
                done_raw_s = 1'b0;
            end
            MC_DONE: begin
                op_ex_s    = 1'b0;
                done_raw_s = 1'b1;
            end
            default: begin
                op_ex_s    = 1'b0;
                done_raw_s = 1'b0;
            end
        endcase
    end

    // Outputs are zero-latency; reset and flush mask them in the same cycle
    always_comb begin
        mc_done = done_raw_s & ~kill_s;
        mc_busy = (state_r == MC_RUN) & ~reset;
        if (reset) begin
            mc_cnt = 6'd0;
        end else begin
            mc_cnt = cnt_r;
        end
    end

    pipe_stall_enc u_enc (
        .req_id   (stall_req_id),
        .req_ex   (stall_req_ex | op_ex_s),
        .req_mem  (stall_req_mem),
        .kill     (kill_s),
        .stall_en (stall_en)
    );

    // Sequencer state and remaining-cycle counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= MC_IDLE;
            cnt_r   <= 6'd0;
        end else if (flush) begin
            state_r <= MC_IDLE;
            cnt_r   <= 6'd0;
        end else begin
            case (state_r)
                MC_IDLE: begin
                    if (mc_start && (n_eff_s >= 6'd3)) begin
                        state_r <= MC_RUN;
                        cnt_r   <= n_eff_s - 6'd2;
                    end else if (mc_start && (n_eff_s == 6'd2)) begin
                        state_r <= MC_DONE;
                        cnt_r   <= 6'd0;
                    end else begin
                        state_r <= MC_IDLE;
                        cnt_r   <= 6'd0;
                    end
                end
                MC_RUN: begin
                    // cnt_r <= 1 also guards against wrapping a stale zero
                    if ((cnt_r <= 6'd1) || mc_ready) begin
                        state_r <= MC_DONE;
                        cnt_r   <= 6'd0;
                    end else begin
                        state_r <= MC_RUN;
                        cnt_r   <= cnt_r - 6'd1;
                    end
                end
                MC_DONE: begin
                    state_r <= MC_IDLE;
                    cnt_r   <= 6'd0;
                end
                default: begin
                    state_r <= MC_IDLE;
                    cnt_r   <= 6'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: directed scenarios plus random traffic, checked
// against an op-age model of the stall and multi-cycle rules.
module tb_pipe_stall_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       stall_req_id, stall_req_ex, stall_req_mem;
    logic       mc_start;
    logic [5:0] mc_cycles;
    logic       mc_ready;
    logic       flush;
    logic [5:0] stall_en;
    logic       mc_busy;
    logic       mc_done;
    logic [5:0] mc_cnt;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: an accepted op of length n is in its cycle m_age (2..n)
    bit   m_active = 1'b0;
    int   m_age = 0;
    int   m_n = 0;
    logic [5:0] e_stall, e_cnt;
    logic       e_busy, e_done;

    always #5 clk = ~clk;

    pipe_stall_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .stall_req_id  (stall_req_id),
        .stall_req_ex  (stall_req_ex),
        .stall_req_mem (stall_req_mem),
        .mc_start      (mc_start),
        .mc_cycles     (mc_cycles),
        .mc_ready      (mc_ready),
        .flush         (flush),
        .stall_en      (stall_en),
        .mc_busy       (mc_busy),
        .mc_done       (mc_done),
        .mc_cnt        (mc_cnt)
    );

    function automatic int eff_n(input logic [5:0] c);
        return (c == 6'd0) ? 1 : int'(c);
    endfunction

    task automatic drive(input bit id, input bit ex, input bit mem, input bit start,
                         input logic [5:0] cyc, input bit rdy, input bit fl, input bit rst);
        stall_req_id = id; stall_req_ex = ex; stall_req_mem = mem;
        mc_start = start; mc_cycles = cyc; mc_ready = rdy; flush = fl; reset = rst;
    endtask

    task automatic model_eval();
        bit op_ex;
        int depth;
        op_ex = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_cnt = 6'd0; depth = -1;
        if (!m_active) begin
            if (mc_start && eff_n(mc_cycles) == 1) e_done = 1'b1;
            if (mc_start && eff_n(mc_cycles) >= 2) op_ex = 1'b1;
        end else if (m_age == m_n) begin
            e_done = 1'b1;
        end else begin
            e_busy = 1'b1;
            op_ex = 1'b1;
            e_cnt = 6'(m_n - m_age);
        end
        if (stall_req_id) depth = 2;
        if (stall_req_ex || op_ex) depth = 3;
        if (stall_req_mem) depth = 4;
        e_stall = (depth < 0) ? 6'd0 : 6'((1 << (depth + 1)) - 1);
        if (flush || reset) begin
            e_stall = 6'd0;
            e_done = 1'b0;
        end
        if (reset) begin
            e_busy = 1'b0;
            e_cnt = 6'd0;
        end
    endtask

    task automatic model_advance();
        if (reset || flush) begin
            m_active = 1'b0;
        end else if (!m_active) begin
            if (mc_start && eff_n(mc_cycles) >= 2) begin
                m_active = 1'b1;
                m_age = 2;
                m_n = eff_n(mc_cycles);
            end
        end else if (m_age == m_n) begin
            m_active = 1'b0;
        end else begin
            if (mc_ready) m_n = m_age + 1;
            m_age = m_age + 1;
        end
    endtask

    task automatic test_reset();
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b1, 6'd9, 1'b1, 1'b0, 1'b1);
            @(negedge clk);
            vectors++;
            if ({stall_en, mc_busy, mc_done, mc_cnt} !== 14'd0) begin
                miscompares++;
                $display("FAIL reset cyc%0d: stall=%b busy=%b done=%b cnt=%0d, want all zero",
                         c, stall_en, mc_busy, mc_done, mc_cnt);
            end
            @(posedge clk); model_advance(); #1;
        end
    endtask

    task automatic test_priority();
        for (int k = 0; k < 8; k++) begin
            drive(k[0], k[1], k[2], 1'b0, 6'd0, 1'b0, 1'b0, 1'b0);
            @(negedge clk); model_eval();
            vectors++;
            if (stall_en !== e_stall || mc_busy !== 1'b0 || mc_done !== 1'b0) begin
                miscompares++;
                $display("FAIL priority req=%b: stall=%b busy=%b done=%b, want stall=%b busy=0 done=0",
                         k[2:0], stall_en, mc_busy, mc_done, e_stall);
            end
            @(posedge clk); model_advance(); #1;
        end
    endtask

    task automatic test_mc5();
        int stalls = 0, busys = 0, done_cyc = 0;
        for (int c = 1; c <= 7; c++) begin
            drive(1'b0, 1'b0, 1'b0, c == 1, 6'd5, 1'b0, 1'b0, 1'b0);
            @(negedge clk); model_eval();
            vectors++;
            if ({stall_en, mc_busy, mc_done, mc_cnt} !== {e_stall, e_busy, e_done, e_cnt}) begin
                miscompares++;
                $display("FAIL mc5 cyc%0d: stall=%b busy=%b done=%b cnt=%0d, want %b %b %b %0d",
                         c, stall_en, mc_busy, mc_done, mc_cnt, e_stall, e_busy, e_done, e_cnt);
            end
            if (stall_en == 6'b001111) stalls++;
            if (mc_busy) busys++;
            if (mc_done && stall_en == 6'd0) done_cyc = c;
            @(posedge clk); model_advance(); #1;
        end
        vectors++;
        if (stalls != 4 || busys != 3 || done_cyc != 5) begin
            miscompares++;
            $display("FAIL mc5 totals: stalls=%0d busy=%0d done_cyc=%0d, want 4 3 5",
                     stalls, busys, done_cyc);
        end
    endtask

    task automatic test_mc_short();
        logic [5:0] lens [3];
        lens[0] = 6'd1; lens[1] = 6'd0; lens[2] = 6'd2;
        for (int i = 0; i < 3; i++) begin
            for (int c = 1; c <= 3; c++) begin
                drive(1'b0, 1'b0, 1'b0, c == 1, lens[i], 1'b0, 1'b0, 1'b0);
                @(negedge clk); model_eval();
                vectors++;
                if ({stall_en, mc_busy, mc_done, mc_cnt} !== {e_stall, e_busy, e_done, e_cnt}) begin
                    miscompares++;
                    $display("FAIL short N=%0d cyc%0d: stall=%b busy=%b done=%b cnt=%0d, want %b %b %b %0d",
                             lens[i], c, stall_en, mc_busy, mc_done, mc_cnt, e_stall, e_busy, e_done, e_cnt);
                end
                @(posedge clk); model_advance(); #1;
            end
        end
    endtask

    task automatic test_mc_ready();
        int done_cyc = 0;
        for (int c = 1; c <= 8; c++) begin
            drive(1'b0, 1'b0, 1'b0, c == 1, 6'd34, c == 4, 1'b0, 1'b0);
            @(negedge clk); model_eval();
            vectors++;
            if ({stall_en, mc_busy, mc_done, mc_cnt} !== {e_stall, e_busy, e_done, e_cnt}) begin
                miscompares++;
                $display("FAIL ready cyc%0d: stall=%b busy=%b done=%b cnt=%0d, want %b %b %b %0d",
                         c, stall_en, mc_busy, mc_done, mc_cnt, e_stall, e_busy, e_done, e_cnt);
            end
            if (mc_done) done_cyc = c;
            @(posedge clk); model_advance(); #1;
        end
        vectors++;
        if (done_cyc != 5) begin
            miscompares++;
            $display("FAIL ready done cycle: got %0d, want 5", done_cyc);
        end
    endtask

    task automatic test_flush();
        int dones = 0;
        for (int c = 1; c <= 8; c++) begin
            drive(1'b1, 1'b0, c == 3, c == 1, 6'd10, 1'b0, c == 3, 1'b0);
            @(negedge clk); model_eval();
            vectors++;
            if ({stall_en, mc_busy, mc_done, mc_cnt} !== {e_stall, e_busy, e_done, e_cnt}) begin
                miscompares++;
                $display("FAIL flush cyc%0d: stall=%b busy=%b done=%b cnt=%0d, want %b %b %b %0d",
                         c, stall_en, mc_busy, mc_done, mc_cnt, e_stall, e_busy, e_done, e_cnt);
            end
            if (mc_done) dones++;
            @(posedge clk); model_advance(); #1;
        end
        vectors++;
        if (dones != 0) begin
            miscompares++;
            $display("FAIL flush done pulses: got %0d, want 0", dones);
        end
    endtask

    task automatic test_reset_mid_run();
        int dones = 0;
        for (int c = 1; c <= 9; c++) begin
            drive(1'b0, 1'b0, 1'b1, c == 1, 6'd20, 1'b0, 1'b0, c == 4 || c == 5);
            @(negedge clk); model_eval();
            vectors++;
            if ({stall_en, mc_busy, mc_done, mc_cnt} !== {e_stall, e_busy, e_done, e_cnt}) begin
                miscompares++;
                $display("FAIL rst_run cyc%0d: stall=%b busy=%b done=%b cnt=%0d, want %b %b %b %0d",
                         c, stall_en, mc_busy, mc_done, mc_cnt, e_stall, e_busy, e_done, e_cnt);
            end
            if (c >= 4 && (mc_done || mc_busy)) dones++;
            @(posedge clk); model_advance(); #1;
        end
        vectors++;
        if (dones != 0) begin
            miscompares++;
            $display("FAIL rst_run op survived reset: %0d busy/done cycles, want 0", dones);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            drive($urandom_range(3) == 0, $urandom_range(5) == 0, $urandom_range(7) == 0,
                  $urandom_range(5) == 0,
                  ($urandom_range(2) == 0) ? 6'($urandom_range(3)) : 6'($urandom_range(63)),
                  $urandom_range(15) == 0, $urandom_range(39) == 0, $urandom_range(199) == 0);
            @(negedge clk); model_eval();
            vectors++;
            if ({stall_en, mc_busy, mc_done, mc_cnt} !== {e_stall, e_busy, e_done, e_cnt}) begin
                miscompares++;
                $display("FAIL random cyc%0d: stall=%b busy=%b done=%b cnt=%0d, want %b %b %b %0d",
                         c, stall_en, mc_busy, mc_done, mc_cnt, e_stall, e_busy, e_done, e_cnt);
            end
            @(posedge clk); model_advance(); #1;
        end
    endtask

    initial begin
        test_reset();
        test_priority();
        test_mc5();
        test_mc_short();
        test_mc_ready();
        test_flush();
        test_reset_mid_run();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipe_stall_ctrl.md
PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

Interface
REQ-001 Clocking SHALL be one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 stall_req_id  input  1  ID-stage hazard request (e.g. load-use).
REQ-005 stall_req_ex  input  1  EX-stage single-cycle stall request.
REQ-006 stall_req_mem  input  1  MEM-stage stall request.
REQ-007 mc_start  input  1  one-cycle pulse: a multi-cycle op has entered EX this cycle.
REQ-008 mc_cycles  input  6  total EX occupancy N of that op, sampled only with mc_start; 0 is treated as 1.
REQ-009 mc_ready  input  1  multi-cycle unit finished early; result is valid next cycle.
REQ-010 flush  input  1  cancel the in-flight multi-cycle op and all stalls.
REQ-011 stall_en  output  6  stall vector: bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB.
REQ-012 mc_busy  output  1  high in RUN state.
REQ-013 mc_done  output  1  high in the cycle the multi-cycle result is final (EX cycle N).
REQ-014 mc_cnt  output  6  remaining RUN cycles (registered counter value).

Function
REQ-015 Stall encodings SHALL be: none 000000, ID 000111, EX 001111, MEM 011111; stage k stalls all earlier stages.
REQ-016 Priority SHALL be MEM > EX (request or multi-cycle) > ID; stall_en is the single encoding of the highest active source.
REQ-017 stall_en, mc_busy and mc_done SHALL be combinational from state, counter and current inputs (zero-cycle latency).
REQ-018 FSM states SHALL be IDLE, RUN, DONE.
REQ-019 IDLE with mc_start and N<=1: stay IDLE, mc_done=1 this cycle, no EX stall from the op.
REQ-020 IDLE with mc_start and N=2: EX stall this cycle, next state DONE.
REQ-021 IDLE with mc_start and N>=3: EX stall this cycle, mc_cnt<=N-2, next state RUN.
REQ-022 RUN: EX stall asserted, mc_cnt decrements by 1 per cycle; when mc_cnt==1 or mc_ready, next state DONE.
REQ-023 DONE: no stall from the op, mc_done=1, next state IDLE; an N-cycle op therefore stalls EX for exactly N-1 cycles.
REQ-024 mc_start outside IDLE SHALL be ignored (EX is stalled, so it cannot legally occur).
REQ-025 mc_ready outside RUN SHALL be ignored; mc_ready and mc_cnt==1 together give a single DONE.
REQ-026 flush SHALL override everything: stall_en=000000, mc_done=0 this cycle, next state IDLE, mc_cnt<=0.
REQ-027 stall_req_mem during RUN SHALL give 011111 while mc_cnt still decrements (the unit keeps computing).
REQ-028 mc_cnt SHALL never underflow; it holds 0 outside RUN.

Reset
REQ-029 While reset is high: state IDLE, mc_cnt=0, stall_en=000000, mc_busy=0, mc_done=0, regardless of other inputs.
REQ-030 Reset mid-RUN SHALL abandon the op with no mc_done pulse.

Structure
REQ-031 The shared package SHALL hold the four stall-vector constants, the stall bit indices, and the FSM state enum.
REQ-032 One sub-module, pipe_stall_enc, SHALL be the combinational priority encoder (requests -> stall_en); the FSM and counter stay in pipe_stall_ctrl.

Verification
REQ-033 stall_req_id=1 alone -> stall_en=000111; with stall_req_ex=1 also -> 001111; add stall_req_mem -> 011111.
REQ-034 mc_start, mc_cycles=5 -> stall_en=001111 for 4 cycles, mc_busy=1 for 3 of them, mc_done=1 on cycle 5 with stall_en=000000.
REQ-035 mc_start, mc_cycles=1 and mc_cycles=0 -> mc_done=1 the same cycle, no stall; mc_cycles=2 -> 1 stall cycle then mc_done.
REQ-036 mc_cycles=34, mc_ready pulsed in the 3rd RUN cycle -> DONE on the next cycle, mc_done=1, then IDLE.
REQ-037 flush in the 2nd RUN cycle of mc_cycles=10 -> stall_en=000000 the same cycle, IDLE next, no mc_done.
REQ-038 reset asserted in RUN with stall_req_mem=1 -> all outputs 0 while reset is high, IDLE afterwards.
